// File: rtl/async_fifo16_wr_arb.sv
// async_fifo16_wr_arb
// Write-side scheduler that lets N_REQ requesters share the single write port
// of an async_fifo16. It lives in the FIFO write clock domain and drives the
// FIFO's DIN/DIN_DV directly. Requesters are served round-robin with bursts of
// at most MAX_BURST beats. The FIFO has no full flag, so free entries are
// tracked with a credit counter. The read side returns credits as pulses that
// are already synchronised into CLK.
//
// Ports:
//   CLK          write clock, same as the FIFO W_CLK
//   RST          synchronous active-high reset
//   REQ_DIN      requester data, slice i = [i*WIDTH +: WIDTH]
//   REQ_DV       per-requester data valid
//   REQ_RDY      per-requester ready (combinational, only the granted bit can be set)
//   GRANT        one-hot current grant (registered)
//   FIFO_DIN     data to the FIFO DIN (registered)
//   FIFO_DIN_DV  write strobe to the FIFO DIN_DV (registered)
//   CREDIT_RET   one-cycle pulse per entry consumed on the read side
//   CREDITS      current free-entry count
//   OVF_ERR      sticky flag: a credit came back while CREDITS was already DEPTH
module async_fifo16_wr_arb #(
    parameter int N_REQ     = 4,
    parameter int WIDTH     = 2,
    parameter int DEPTH     = 15,
    parameter int MAX_BURST = 4
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [N_REQ*WIDTH-1:0]   REQ_DIN,
    input  logic [N_REQ-1:0]         REQ_DV,
    output logic [N_REQ-1:0]         REQ_RDY,
    output logic [N_REQ-1:0]         GRANT,
    output logic [WIDTH-1:0]         FIFO_DIN,
    output logic                     FIFO_DIN_DV,
    input  logic                     CREDIT_RET,
    output logic [4:0]               CREDITS,
    output logic                     OVF_ERR
);

    localparam int          IDXW        = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int          IDXWP1      = IDXW + 1;
    localparam logic [4:0]  DEPTH_C     = 5'(DEPTH);
    localparam logic [3:0]  MAX_BURST_C = 4'(MAX_BURST);

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    state_t              state_q;
    logic [N_REQ-1:0]    grant_q;
    logic [IDXW-1:0]     grantIdx_q;
    logic [IDXW-1:0]     lastWinner_q;
    logic [3:0]          beatCnt_q;
    logic [4:0]          credits_q;
    logic [4:0]          credits_d;
    logic                ovfErr_q;
    logic                ovfErr_d;
    logic [WIDTH-1:0]    fifoDin_q;
    logic                fifoDinDv_q;

    logic                beat;
    logic [WIDTH-1:0]    grantData;
    logic                arbFound;
    logic [IDXW-1:0]     arbIdx;
    logic [IDXWP1-1:0]   idxWide;

    // Only the granted requester may see ready, and only while credits remain.
    // A credit returned in the same cycle as CREDITS==0 is visible next cycle.
    assign REQ_RDY   = (state_q == XFER && credits_q != 5'd0) ? grant_q : '0;
    assign beat      = |(REQ_DV & REQ_RDY);
    assign grantData = REQ_DIN[int'(grantIdx_q)*WIDTH +: WIDTH];

    // Round-robin search starting just above the last winner, wrapping around.
    always_comb begin
        arbFound = 1'b0;
        arbIdx   = '0;
        idxWide  = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            idxWide = {1'b0, lastWinner_q} + IDXWP1'(k);
            if (idxWide >= IDXWP1'(N_REQ)) begin
                idxWide = idxWide - IDXWP1'(N_REQ);
            end
            if (!arbFound && REQ_DV[idxWide[IDXW-1:0]]) begin
                arbFound = 1'b1;
                arbIdx   = idxWide[IDXW-1:0];
            end
        end
    end

    // A beat and a returned credit in the same cycle cancel out. A return
    // while already full is dropped and flagged.
    always_comb begin
        credits_d = credits_q;
        ovfErr_d  = ovfErr_q;
        if (beat && !CREDIT_RET) begin
            credits_d = credits_q - 5'd1;
        end else if (CREDIT_RET && !beat) begin
            if (credits_q == DEPTH_C) begin
                ovfErr_d = 1'b1;
            end else begin
                credits_d = credits_q + 5'd1;
            end
        end
    end

    // Arbitration FSM with registered FIFO write outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            grantIdx_q   <= '0;
            lastWinner_q <= IDXW'(N_REQ - 1);
            beatCnt_q    <= 4'd0;
            credits_q    <= DEPTH_C;
            ovfErr_q     <= 1'b0;
            fifoDin_q    <= '0;
            fifoDinDv_q  <= 1'b0;
        end else begin
            credits_q   <= credits_d;
            ovfErr_q    <= ovfErr_d;
            fifoDinDv_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    grant_q <= '0;
                    if (arbFound && credits_q != 5'd0) begin
                        grant_q         <= '0;
                        grant_q[arbIdx] <= 1'b1;
                        grantIdx_q      <= arbIdx;
                        lastWinner_q    <= arbIdx;
                        beatCnt_q       <= 4'd0;
                        state_q         <= XFER;
                    end
                end
                XFER: begin
                    if (beat) begin
                        fifoDin_q   <= grantData;
                        fifoDinDv_q <= 1'b1;
                        beatCnt_q   <= beatCnt_q + 4'd1;
                        if (beatCnt_q + 4'd1 == MAX_BURST_C) begin
                            grant_q <= '0;
                            state_q <= IDLE;
                        end
                    end else if (!REQ_DV[grantIdx_q]) begin
                        // Requester went away: give up the grant and re-arbitrate.
                        grant_q <= '0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    grant_q <= '0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign GRANT       = grant_q;
    assign FIFO_DIN    = fifoDin_q;
    assign FIFO_DIN_DV = fifoDinDv_q;
    assign CREDITS     = credits_q;
    assign OVF_ERR     = ovfErr_q;

endmodule

// File: tb/tb_async_fifo16_wr_arb.sv
// tb_async_fifo16_wr_arb
// Directed bench for async_fifo16_wr_arb with default parameters
// (N_REQ=4, WIDTH=2, DEPTH=15, MAX_BURST=4). Inputs change and outputs are
// sampled on the falling edge, away from the active rising edge.
module tb_async_fifo16_wr_arb;

    logic       clk;
    logic       rst;
    logic [7:0] reqDin;
    logic [3:0] reqDv;
    logic [3:0] reqRdy;
    logic [3:0] grant;
    logic [1:0] fifoDin;
    logic       fifoDinDv;
    logic       creditRet;
    logic [4:0] credits;
    logic       ovfErr;

    int errorCount = 0;
    int checkCount = 0;

    async_fifo16_wr_arb #(
        .N_REQ(4), .WIDTH(2), .DEPTH(15), .MAX_BURST(4)
    ) dut (
        .CLK(clk),
        .RST(rst),
        .REQ_DIN(reqDin),
        .REQ_DV(reqDv),
        .REQ_RDY(reqRdy),
        .GRANT(grant),
        .FIFO_DIN(fifoDin),
        .FIFO_DIN_DV(fifoDinDv),
        .CREDIT_RET(creditRet),
        .CREDITS(credits),
        .OVF_ERR(ovfErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value and tally it.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Advance one full clock and land on the next falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Set the requester inputs for the coming cycle.
    task automatic applyStimulus(input logic [3:0] dv, input logic [7:0] din,
                                 input logic ret);
        reqDv     = dv;
        reqDin    = din;
        creditRet = ret;
        #1;
    endtask

    // Directed sequence walking through the arbitration and credit scenarios.
    initial begin
        logic [1:0] burstData [4];
        burstData[0] = 2'd1;
        burstData[1] = 2'd2;
        burstData[2] = 2'd3;
        burstData[3] = 2'd0;

        rst = 1'b1;
        applyStimulus(4'b0000, 8'h00, 1'b0);
        @(negedge clk);
        tick();
        rst = 1'b0;

        checkOutput("rst_grant", 32'(grant), 32'h0);
        checkOutput("rst_rdy", 32'(reqRdy), 32'h0);
        checkOutput("rst_dv", 32'(fifoDinDv), 32'h0);
        checkOutput("rst_din", 32'(fifoDin), 32'h0);
        checkOutput("rst_credits", 32'(credits), 32'd15);
        checkOutput("rst_ovf", 32'(ovfErr), 32'h0);

        // Single requester, full burst then re-grant after the bubble.
        applyStimulus(4'b0001, 8'h01, 1'b0);
        tick();
        checkOutput("t1_grant", 32'(grant), 32'b0001);
        checkOutput("t1_dv_idle", 32'(fifoDinDv), 32'h0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(4'b0001, {6'b0, burstData[i]}, 1'b0);
            tick();
            checkOutput("t1_beat_dv", 32'(fifoDinDv), 32'h1);
            checkOutput("t1_beat_din", 32'(fifoDin), 32'(burstData[i]));
        end
        checkOutput("t1_grant_drop", 32'(grant), 32'h0);
        checkOutput("t1_credits11", 32'(credits), 32'd11);
        applyStimulus(4'b0001, 8'h01, 1'b0);
        tick();
        checkOutput("t1_bubble_dv", 32'(fifoDinDv), 32'h0);
        checkOutput("t1_regrant", 32'(grant), 32'b0001);
        tick();
        checkOutput("t1_next_din", 32'(fifoDin), 32'd1);
        checkOutput("t1_credits10", 32'(credits), 32'd10);

        // All four requesters, round-robin until credits run out.
        rst = 1'b1;
        applyStimulus(4'b0000, 8'h00, 1'b0);
        tick();
        rst = 1'b0;
        applyStimulus(4'b1111, {2'd3, 2'd2, 2'd1, 2'd0}, 1'b0);
        for (int r = 0; r < 4; r++) begin
            tick();
            checkOutput("t2_grant", 32'(grant), 32'(4'b0001 << r));
            checkOutput("t2_arb_dv", 32'(fifoDinDv), 32'h0);
            for (int b = 0; b < ((r == 3) ? 3 : 4); b++) begin
                tick();
                checkOutput("t2_beat_dv", 32'(fifoDinDv), 32'h1);
                checkOutput("t2_beat_din", 32'(fifoDin), 32'(r));
            end
        end
        checkOutput("t2_credits0", 32'(credits), 32'd0);
        checkOutput("t2_stall_rdy", 32'(reqRdy), 32'h0);
        tick();
        checkOutput("t2_stall_dv", 32'(fifoDinDv), 32'h0);
        checkOutput("t2_stall_grant", 32'(grant), 32'b1000);
        checkOutput("t2_stall_credits", 32'(credits), 32'd0);

        // One returned credit releases exactly one beat from requester 3.
        applyStimulus(4'b1111, {2'd3, 2'd2, 2'd1, 2'd0}, 1'b1);
        checkOutput("t3_rdy_same_cycle", 32'(reqRdy), 32'h0);
        tick();
        applyStimulus(4'b1111, {2'd3, 2'd2, 2'd1, 2'd0}, 1'b0);
        checkOutput("t3_credits1", 32'(credits), 32'd1);
        checkOutput("t3_rdy", 32'(reqRdy), 32'b1000);
        tick();
        checkOutput("t3_beat_dv", 32'(fifoDinDv), 32'h1);
        checkOutput("t3_beat_din", 32'(fifoDin), 32'd3);
        checkOutput("t3_credits0", 32'(credits), 32'd0);
        checkOutput("t3_grant_drop", 32'(grant), 32'h0);

        // Refill to 7, then a beat and a return in the same cycle.
        applyStimulus(4'b0000, {2'd3, 2'd2, 2'd1, 2'd2}, 1'b1);
        for (int i = 0; i < 7; i++) tick();
        checkOutput("t4_credits7", 32'(credits), 32'd7);
        applyStimulus(4'b0001, {2'd3, 2'd2, 2'd1, 2'd2}, 1'b0);
        tick();
        checkOutput("t4_grant", 32'(grant), 32'b0001);
        applyStimulus(4'b0001, {2'd3, 2'd2, 2'd1, 2'd2}, 1'b1);
        tick();
        checkOutput("t4_both_dv", 32'(fifoDinDv), 32'h1);
        checkOutput("t4_both_din", 32'(fifoDin), 32'd2);
        checkOutput("t4_both_credits", 32'(credits), 32'd7);
        applyStimulus(4'b0000, {2'd3, 2'd2, 2'd1, 2'd0}, 1'b0);
        tick();
        checkOutput("t4_drop_grant", 32'(grant), 32'h0);
        applyStimulus(4'b0000, {2'd3, 2'd2, 2'd1, 2'd0}, 1'b1);
        for (int i = 0; i < 8; i++) tick();
        checkOutput("t4_credits15", 32'(credits), 32'd15);
        checkOutput("t4_ovf_clear", 32'(ovfErr), 32'h0);
        tick();
        checkOutput("t4_ovf_credits", 32'(credits), 32'd15);
        checkOutput("t4_ovf_set", 32'(ovfErr), 32'h1);
        applyStimulus(4'b0000, {2'd3, 2'd2, 2'd1, 2'd0}, 1'b0);
        tick();
        tick();
        checkOutput("t4_ovf_sticky", 32'(ovfErr), 32'h1);

        // Requester 2 drops mid-burst, priority wraps past 3 and 0 to 1.
        applyStimulus(4'b0100, {2'd3, 2'd2, 2'd1, 2'd0}, 1'b0);
        tick();
        checkOutput("t5_grant2", 32'(grant), 32'b0100);
        applyStimulus(4'b0110, {2'd3, 2'd2, 2'd1, 2'd0}, 1'b0);
        tick();
        checkOutput("t5_beat1_din", 32'(fifoDin), 32'd2);
        tick();
        checkOutput("t5_beat2_dv", 32'(fifoDinDv), 32'h1);
        applyStimulus(4'b0010, {2'd3, 2'd2, 2'd1, 2'd0}, 1'b0);
        tick();
        checkOutput("t5_drop_dv", 32'(fifoDinDv), 32'h0);
        checkOutput("t5_drop_grant", 32'(grant), 32'h0);
        tick();
        checkOutput("t5_wrap_grant1", 32'(grant), 32'b0010);
        checkOutput("t5_credits13", 32'(credits), 32'd13);
        applyStimulus(4'b1000, {2'd3, 2'd2, 2'd1, 2'd0}, 1'b0);
        tick();
        checkOutput("t5_drop1_grant", 32'(grant), 32'h0);
        tick();
        checkOutput("t5_grant3", 32'(grant), 32'b1000);

        // Reset in the middle of a burst.
        applyStimulus(4'b0001, {2'd3, 2'd2, 2'd1, 2'd3}, 1'b0);
        tick();
        tick();
        checkOutput("t6_grant0", 32'(grant), 32'b0001);
        checkOutput("t6_rdy", 32'(reqRdy), 32'b0001);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("t6_rst_grant", 32'(grant), 32'h0);
        checkOutput("t6_rst_dv", 32'(fifoDinDv), 32'h0);
        checkOutput("t6_rst_credits", 32'(credits), 32'd15);
        checkOutput("t6_rst_ovf", 32'(ovfErr), 32'h0);
        applyStimulus(4'b1100, {2'd3, 2'd2, 2'd1, 2'd0}, 1'b0);
        tick();
        checkOutput("t6_first_grant", 32'(grant), 32'b0100);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
